// File: rtl/instr_loader.sv
// instr_loader: streams a program into instruction memory, holding the MIPS core's PC in reset until loaded.
// Optional feature macro LOADER_CHECKSUM_EN adds the expSum port and a wrapping-sum check before release.
module instr_loader #(
  parameter int MAX_WORDS = 256,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] progLength,
  input  logic             inValid,
  input  logic [31:0]      inData,
`ifdef LOADER_CHECKSUM_EN
  input  logic [31:0]      expSum,
`endif
  output logic             inReady,
  output logic [31:0]      instrAddr,
  output logic [31:0]      instrIn,
  output logic             instrWrite,
  output logic             instrRead,
  output logic             pcReset,
  output logic             pcWrite,
  output logic             initializing,
  output logic [LEN_W-1:0] loadedCount,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    ERROR   = 3'd4
  } state_t;

  localparam logic [LEN_W:0] MaxLen = (LEN_W+1)'(MAX_WORDS);

  state_t           state_r;
  state_t           nextState_s;
  logic [LEN_W-1:0] progLen_r;
  logic             lengthOk_s;
  logic             startSeen_s;
  logic             startAccept_s;
  logic             handshake_s;
  logic             lastWord_s;
  logic             inReady_s;
  logic             pcReset_s;
  logic             pcWrite_s;
  logic             instrRead_s;
  logic             initializing_s;
  logic             done_s;
  logic             error_s;

  assign lengthOk_s    = (progLength != {LEN_W{1'b0}}) && ({1'b0, progLength} <= MaxLen);
  // start only matters outside an active load or its settle cycle
  assign startSeen_s   = start && (state_r != LOAD) && (state_r != RELEASE);
  assign startAccept_s = startSeen_s && lengthOk_s;
  assign handshake_s   = inReady & inValid;
  assign lastWord_s    = handshake_s && ((loadedCount + {{(LEN_W-1){1'b0}}, 1'b1}) == progLen_r);

  assign instrWrite = handshake_s;
  assign instrIn    = inData;
  assign instrAddr  = 32'({loadedCount, 2'b00});

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_r;
  logic [31:0] expSum_r;
  logic        sumOk_s;

  function automatic logic [31:0] sumAdd(input logic [31:0] acc, input logic [31:0] word);
    return acc + word;
  endfunction

  // Wrapping sum of accepted words plus the expected value captured with start
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r    <= 32'd0;
      expSum_r <= 32'd0;
    end else if (startSeen_s) begin
      sum_r    <= 32'd0;
      expSum_r <= expSum;
    end else if (handshake_s) begin
      sum_r    <= sumAdd(sum_r, inData);
      expSum_r <= expSum_r;
    end else begin
      sum_r    <= sum_r;
      expSum_r <= expSum_r;
    end
  end

  assign sumOk_s = (sum_r == expSum_r);
`endif

  // Next-state decode
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE, RUN, ERROR: begin
        if (start) begin
          if (lengthOk_s) begin
            nextState_s = LOAD;
          end else begin
            nextState_s = ERROR;
          end
        end else begin
          nextState_s = state_r;
        end
      end
      LOAD: begin
        if (lastWord_s) begin
          nextState_s = RELEASE;
        end else begin
          nextState_s = LOAD;
        end
      end
      RELEASE: begin
`ifdef LOADER_CHECKSUM_EN
        if (sumOk_s) begin
          nextState_s = RUN;
        end else begin
          nextState_s = ERROR;
        end
`else
        nextState_s = RUN;
`endif
      end
      default: nextState_s = IDLE;
    endcase
  end

  // Control outputs decoded from the next state so they are registered alongside it
  always_comb begin
    inReady_s      = 1'b0;
    pcReset_s      = 1'b1;
    pcWrite_s      = 1'b0;
    instrRead_s    = 1'b0;
    initializing_s = 1'b1;
    done_s         = 1'b0;
    error_s        = 1'b0;
    case (nextState_s)
      LOAD: inReady_s = 1'b1;
      RUN: begin
        pcReset_s      = 1'b0;
        pcWrite_s      = 1'b1;
        instrRead_s    = 1'b1;
        initializing_s = 1'b0;
        done_s         = 1'b1;
      end
      ERROR:   error_s   = 1'b1;
      default: inReady_s = 1'b0;
    endcase
  end

  // State and registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      inReady      <= 1'b0;
      pcReset      <= 1'b1;
      pcWrite      <= 1'b0;
      instrRead    <= 1'b0;
      initializing <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_r      <= nextState_s;
      inReady      <= inReady_s;
      pcReset      <= pcReset_s;
      pcWrite      <= pcWrite_s;
      instrRead    <= instrRead_s;
      initializing <= initializing_s;
      done         <= done_s;
      error        <= error_s;
    end
  end

  // Latched length and saturating word counter
  always_ff @(posedge clk) begin
    if (reset) begin
      progLen_r   <= {LEN_W{1'b0}};
      loadedCount <= {LEN_W{1'b0}};
    end else if (startAccept_s) begin
      progLen_r   <= progLength;
      loadedCount <= {LEN_W{1'b0}};
    end else if (handshake_s && (loadedCount < progLen_r)) begin
      progLen_r   <= progLen_r;
      loadedCount <= loadedCount + {{(LEN_W-1){1'b0}}, 1'b1};
    end else begin
      progLen_r   <= progLen_r;
      loadedCount <= loadedCount;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: per-cycle vector table plus hand-written load/reset/checksum sequences.
module tb_instr_loader;
  localparam int MAX_WORDS = 256;
  localparam int LEN_W     = 16;

  localparam logic [6:0] CIDLE = 7'b0100100;  // {inReady,pcReset,pcWrite,instrRead,initializing,done,error}
  localparam logic [6:0] CLOAD = 7'b1100100;
  localparam logic [6:0] CREL  = 7'b0100100;
  localparam logic [6:0] CRUN  = 7'b0011010;
  localparam logic [6:0] CERR  = 7'b0100101;

  localparam logic [31:0] A0 = 32'h2010_0005;
  localparam logic [31:0] A1 = 32'h2011_0003;
  localparam logic [31:0] A2 = 32'h0211_9020;
  localparam logic [31:0] B0 = 32'hAC10_0000;
  localparam logic [31:0] B1 = 32'h0800_0000;

  typedef struct {
    logic             st;
    logic [LEN_W-1:0] len;
    logic             vld;
    logic [31:0]      data;
    logic [31:0]      sum;
    logic             wr;
    logic [31:0]      addr;
    logic [6:0]       ctl;
    logic [LEN_W-1:0] cnt;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] progLength;
  logic             inValid;
  logic [31:0]      inData;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]      expSum;
`endif
  logic             inReady;
  logic [31:0]      instrAddr;
  logic [31:0]      instrIn;
  logic             instrWrite;
  logic             instrRead;
  logic             pcReset;
  logic             pcWrite;
  logic             initializing;
  logic [LEN_W-1:0] loadedCount;
  logic             done;
  logic             error;

  logic [31:0] mem [0:255];
  logic [31:0] wrAddr [$];
  vec_t        tv [$];
  int          nApplied = 0;
  int          nMiscompare = 0;
  int          doneAt;
  int          pcFallAt;
  int          waitCnt;

  always #5 clk = ~clk;

  instr_loader #(.MAX_WORDS(MAX_WORDS), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .progLength(progLength),
    .inValid(inValid),
    .inData(inData),
`ifdef LOADER_CHECKSUM_EN
    .expSum(expSum),
`endif
    .inReady(inReady),
    .instrAddr(instrAddr),
    .instrIn(instrIn),
    .instrWrite(instrWrite),
    .instrRead(instrRead),
    .pcReset(pcReset),
    .pcWrite(pcWrite),
    .initializing(initializing),
    .loadedCount(loadedCount),
    .done(done),
    .error(error)
  );

  // Instruction-memory model and write-address log
  always @(posedge clk) begin
    if (instrWrite) begin
      mem[instrAddr[9:2]] <= instrIn;
      wrAddr.push_back(instrAddr);
    end
  end

  function automatic logic [6:0] ctlNow();
    return {inReady, pcReset, pcWrite, instrRead, initializing, done, error};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiscompare++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic st, input logic [LEN_W-1:0] len, input logic vld,
                        input logic [31:0] data, input logic [31:0] sum, input logic wr,
                        input logic [31:0] addr, input logic [6:0] ctl, input logic [LEN_W-1:0] cnt);
    tv.push_back(vec_t'{st, len, vld, data, sum, wr, addr, ctl, cnt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; progLength = 16'd0; inValid = 1'b0; inData = 32'd0;
`ifdef LOADER_CHECKSUM_EN
    expSum = 32'd0;
`endif
    tick();
    tick();
    reset = 1'b0;
    check("reset_state", {41'd0, ctlNow(), loadedCount}, {41'd0, CIDLE, 16'd0});

    // illegal lengths, legal start out of ERROR, 3-word load with gaps, reload from RUN
    addVec(1'b1, 16'd0,   1'b1, 32'hDEAD_0000, 32'd0,   1'b0, 32'd0,  CERR,  16'd0);
    addVec(1'b1, 16'd257, 1'b1, 32'hDEAD_0001, 32'd0,   1'b0, 32'd0,  CERR,  16'd0);
    addVec(1'b0, 16'd0,   1'b1, 32'hDEAD_0002, 32'd0,   1'b0, 32'd0,  CERR,  16'd0);
    addVec(1'b1, 16'd3,   1'b0, 32'd0, A0 + A1 + A2,    1'b0, 32'd0,  CLOAD, 16'd0);
    addVec(1'b0, 16'd3,   1'b1, A0,    32'd0,           1'b1, 32'd0,  CLOAD, 16'd1);
    addVec(1'b0, 16'd3,   1'b0, 32'd0, 32'd0,           1'b0, 32'd4,  CLOAD, 16'd1);
    addVec(1'b0, 16'd3,   1'b1, A1,    32'd0,           1'b1, 32'd4,  CLOAD, 16'd2);
    addVec(1'b0, 16'd3,   1'b0, 32'd0, 32'd0,           1'b0, 32'd8,  CLOAD, 16'd2);
    addVec(1'b0, 16'd3,   1'b1, A2,    32'd0,           1'b1, 32'd8,  CREL,  16'd3);
    addVec(1'b0, 16'd3,   1'b0, 32'd0, 32'd0,           1'b0, 32'd12, CRUN,  16'd3);
    addVec(1'b0, 16'd3,   1'b1, 32'h1111_1111, 32'd0,   1'b0, 32'd12, CRUN,  16'd3);
    addVec(1'b1, 16'd2,   1'b0, 32'd0, B0 + B1,         1'b0, 32'd12, CLOAD, 16'd0);
    addVec(1'b0, 16'd2,   1'b1, B0,    32'd0,           1'b1, 32'd0,  CLOAD, 16'd1);
    addVec(1'b0, 16'd2,   1'b1, B1,    32'd0,           1'b1, 32'd4,  CREL,  16'd2);
    addVec(1'b0, 16'd2,   1'b0, 32'd0, 32'd0,           1'b0, 32'd8,  CRUN,  16'd2);

    for (int i = 0; i < tv.size(); i++) begin
      start = tv[i].st; progLength = tv[i].len; inValid = tv[i].vld; inData = tv[i].data;
`ifdef LOADER_CHECKSUM_EN
      expSum = tv[i].sum;
`endif
      #2;
      check($sformatf("vec%0d_comb", i), {31'd0, instrWrite, instrAddr}, {31'd0, tv[i].wr, tv[i].addr});
      tick();
      check($sformatf("vec%0d_regs", i), {41'd0, ctlNow(), loadedCount}, {41'd0, tv[i].ctl, tv[i].cnt});
    end
    check("mem_after_reload", {mem[0], mem[1]}, {B0, B1});
    check("mem_word2_kept", {32'd0, mem[2]}, {32'd0, A2});

    // 17-word load with inValid held high, started from RUN
    start = 1'b1; progLength = 16'd17; inValid = 1'b0; inData = 32'd0;
`ifdef LOADER_CHECKSUM_EN
    expSum = A0 - 32'h0000_0000 + 32'h2010_0005 - A0;
`endif
    wrAddr.delete();
    tick();
    check("run_start_pc", {62'd0, pcReset, pcWrite}, {62'd0, 1'b1, 1'b0});
    start = 1'b0; inValid = 1'b1;
    doneAt = 0; pcFallAt = 0;
    for (int n = 1; n <= 40 && doneAt == 0; n++) begin
      inData = (loadedCount == 16'd0) ? 32'h2010_0005 : 32'd0;
      tick();
      if (!pcReset && pcFallAt == 0) pcFallAt = n + 1;
      if (done) doneAt = n + 1;
    end
    inValid = 1'b0;
    check("load17_done_cycle", 64'(doneAt), 64'd19);
    check("load17_pcreset_fall", 64'(pcFallAt), 64'd19);
    check("load17_nwrites", 64'(wrAddr.size()), 64'd17);
    for (int k = 0; k < 17 && k < wrAddr.size(); k++) begin
      check($sformatf("load17_addr%0d", k), {32'd0, wrAddr[k]}, {32'd0, 32'(k * 4)});
    end
    check("load17_mem0", {32'd0, mem[0]}, {32'd0, 32'h2010_0005});

    // reset after 5 of 10 words
    start = 1'b1; progLength = 16'd10;
    tick();
    start = 1'b0; inValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      inData = 32'hC0DE_0000 + 32'(k);
      tick();
    end
    inValid = 1'b0;
    check("midload_count", {48'd0, loadedCount}, {48'd0, 16'd5});
    reset = 1'b1;
    tick();
    check("midload_reset", {41'd0, ctlNow(), loadedCount}, {41'd0, CIDLE, 16'd0});
    for (int k = 0; k < 5; k++) begin
      check($sformatf("retained%0d", k), {32'd0, mem[k]}, {32'd0, 32'hC0DE_0000 + 32'(k)});
    end
    start = 1'b1; progLength = 16'd2;
    tick();
    check("reset_beats_start", {57'd0, ctlNow()}, {57'd0, CIDLE});
    reset = 1'b0; progLength = 16'd256;
`ifdef LOADER_CHECKSUM_EN
    expSum = 32'd0;
`endif
    tick();
    check("max_len_accepted", {57'd0, ctlNow()}, {57'd0, CLOAD});
    start = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;

`ifdef LOADER_CHECKSUM_EN
    for (int pass = 0; pass < 2; pass++) begin
      start = 1'b1; progLength = 16'd3; expSum = (pass == 0) ? 32'd6 : 32'd7;
      tick();
      start = 1'b0; inValid = 1'b1;
      for (int k = 1; k <= 3; k++) begin
        inData = 32'(k);
        tick();
      end
      inValid = 1'b0;
      waitCnt = 0;
      while (!done && !error && waitCnt < 10) begin
        tick();
        waitCnt++;
      end
      if (pass == 0) begin
        check("csum_ok", {61'd0, done, error, pcReset}, {61'd0, 1'b1, 1'b0, 1'b0});
      end else begin
        check("csum_bad", {61'd0, done, error, pcReset}, {61'd0, 1'b0, 1'b1, 1'b1});
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
    $finish;
  end

endmodule
